// File: rtl/sram.sv
// Single-port synchronous SRAM: byte-lane write enables, per-word user sideband, write-first read data.
// Define SRAM_CLEAR_ON_RESET_EN to zero every word and user field on each reset edge.
module sram #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1,
    parameter int BYTE_WIDTH = 8,
    parameter int NUM_WORDS  = 1024,
    localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    localparam int BW = (DATA_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [USER_WIDTH-1:0] wuser_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BW-1:0]         be_i,
    output logic [USER_WIDTH-1:0] ruser_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam logic [AW:0] DEPTH = (AW+1)'(NUM_WORDS);

    logic [DATA_WIDTH-1:0] mem_q  [NUM_WORDS];
    logic [USER_WIDTH-1:0] user_q [NUM_WORDS];

    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [USER_WIDTH-1:0] ruser_q, ruser_d;

    logic                  inRange;
    logic                  memWe;
    logic [DATA_WIDTH-1:0] bitMask;
    logic [DATA_WIDTH-1:0] curWord;
    logic [USER_WIDTH-1:0] curUser;
    logic [DATA_WIDTH-1:0] mergedWord;
    logic [USER_WIDTH-1:0] mergedUser;

    // Expand lane enables to a per-bit mask; the last lane is cut off at DATA_WIDTH.
    always_comb begin
        bitMask = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            bitMask[i] = be_i[i / BYTE_WIDTH];
        end
    end

    always_comb begin
        inRange    = ({1'b0, addr_i} < DEPTH);
        curWord    = inRange ? mem_q[addr_i]  : '0;
        curUser    = inRange ? user_q[addr_i] : '0;
        mergedWord = (curWord & ~bitMask) | (wdata_i & bitMask);
        mergedUser = (|be_i) ? wuser_i : curUser;
        memWe      = req_i & we_i & inRange & ~rst_ni;
    end

    // Read port shows post-write contents on writes, zero for out-of-range, holds when idle.
    always_comb begin
        rdata_d = rdata_q;
        ruser_d = ruser_q;
        if (req_i) begin
            if (!inRange) begin
                rdata_d = '0;
                ruser_d = '0;
            end else if (we_i) begin
                rdata_d = mergedWord;
                ruser_d = mergedUser;
            end else begin
                rdata_d = curWord;
                ruser_d = curUser;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            rdata_q <= '0;
            ruser_q <= '0;
        end else begin
            rdata_q <= rdata_d;
            ruser_q <= ruser_d;
        end
    end

`ifdef SRAM_CLEAR_ON_RESET_EN
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            for (int w = 0; w < NUM_WORDS; w++) begin
                mem_q[w]  <= '0;
                user_q[w] <= '0;
            end
        end else if (memWe) begin
            mem_q[addr_i]  <= mergedWord;
            user_q[addr_i] <= mergedUser;
        end
    end
`else
    // No reset on the array so it maps onto plain memory macros.
    always_ff @(posedge clk_i) begin
        if (memWe) begin
            mem_q[addr_i]  <= mergedWord;
            user_q[addr_i] <= mergedUser;
        end
    end
`endif

    assign rdata_o = rdata_q;
    assign ruser_o = ruser_q;

endmodule

// File: tb/tb_sram.sv
// Directed-vector bench for sram: default 1024-word instance plus a 6-word instance for range checks.
// Honours SRAM_CLEAR_ON_RESET_EN for the post-reset expectations.
module tb_sram;

    logic        clk;
    logic        rst;
    logic        req, we;
    logic [9:0]  addr;
    logic        wuser;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic        ruser;
    logic [63:0] rdata;

    logic        req6, we6;
    logic [2:0]  addr6;
    logic        wuser6;
    logic [63:0] wdata6;
    logic [7:0]  be6;
    logic        ruser6;
    logic [63:0] rdata6;

    int vectors;
    int miscompares;

    sram dut (
        .clk_i   (clk),
        .rst_ni  (rst),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wuser_i (wuser),
        .wdata_i (wdata),
        .be_i    (be),
        .ruser_o (ruser),
        .rdata_o (rdata)
    );

    sram #(.NUM_WORDS(6)) dut6 (
        .clk_i   (clk),
        .rst_ni  (rst),
        .req_i   (req6),
        .we_i    (we6),
        .addr_i  (addr6),
        .wuser_i (wuser6),
        .wdata_i (wdata6),
        .be_i    (be6),
        .ruser_o (ruser6),
        .rdata_o (rdata6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [9:0] a,
                         input logic [63:0] d, input logic [7:0] b, input logic u);
        req = r; we = w; addr = a; wdata = d; be = b; wuser = u;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 10'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
        cycle();
        vectors++;
        if (rdata !== 64'h0) begin
            $display("[TB] FAIL reset_rdata got=%h exp=%h", rdata, 64'h0); miscompares++;
        end
        vectors++;
        if (ruser !== 1'b0) begin
            $display("[TB] FAIL reset_ruser got=%b exp=0", ruser); miscompares++;
        end
        vectors++;
        if (rdata6 !== 64'h0) begin
            $display("[TB] FAIL reset_rdata6 got=%h exp=%h", rdata6, 64'h0); miscompares++;
        end
        drive(1'b0, 1'b0, 10'd0, 64'h0, 8'h00, 1'b0);
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_full_write_read();
        drive(1'b1, 1'b1, 10'd5, 64'h1122_3344_5566_7788, 8'hFF, 1'b1);
        cycle();
        vectors++;
        if (rdata !== 64'h1122_3344_5566_7788) begin
            $display("[TB] FAIL full_write_wf got=%h exp=%h", rdata, 64'h1122_3344_5566_7788); miscompares++;
        end
        drive(1'b1, 1'b0, 10'd5, 64'h0, 8'h00, 1'b0);
        cycle();
        vectors++;
        if (rdata !== 64'h1122_3344_5566_7788) begin
            $display("[TB] FAIL full_read_data got=%h exp=%h", rdata, 64'h1122_3344_5566_7788); miscompares++;
        end
        vectors++;
        if (ruser !== 1'b1) begin
            $display("[TB] FAIL full_read_user got=%b exp=1", ruser); miscompares++;
        end
    endtask

    task automatic test_partial_write();
        drive(1'b1, 1'b1, 10'd5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b0);
        cycle();
        vectors++;
        if (rdata !== 64'h1122_3344_FFFF_FFFF) begin
            $display("[TB] FAIL partial_wf got=%h exp=%h", rdata, 64'h1122_3344_FFFF_FFFF); miscompares++;
        end
        drive(1'b1, 1'b0, 10'd5, 64'h0, 8'h00, 1'b1);
        cycle();
        vectors++;
        if (rdata !== 64'h1122_3344_FFFF_FFFF) begin
            $display("[TB] FAIL partial_read got=%h exp=%h", rdata, 64'h1122_3344_FFFF_FFFF); miscompares++;
        end
        vectors++;
        if (ruser !== 1'b0) begin
            $display("[TB] FAIL partial_user got=%b exp=0", ruser); miscompares++;
        end
    endtask

    task automatic test_write_first();
        drive(1'b1, 1'b1, 10'd9, 64'h0000_0000_0000_00A5, 8'h01, 1'b0);
        cycle();
        vectors++;
        if (rdata[7:0] !== 8'hA5) begin
            $display("[TB] FAIL write_first_lo got=%h exp=a5", rdata[7:0]); miscompares++;
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 1'b0, 10'd5, 64'h0, 8'h00, 1'b0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, i[0], 10'(i * 3 + 1), 64'h0, 8'hFF, 1'b1);
            cycle();
            vectors++;
            if (rdata !== 64'h1122_3344_FFFF_FFFF) begin
                $display("[TB] FAIL hold_cycle%0d got=%h exp=%h", i, rdata, 64'h1122_3344_FFFF_FFFF); miscompares++;
            end
        end
        drive(1'b0, 1'b1, 10'd5, 64'h0, 8'hFF, 1'b1);
        cycle();
        drive(1'b1, 1'b0, 10'd5, 64'h0, 8'h00, 1'b0);
        cycle();
        vectors++;
        if (rdata !== 64'h1122_3344_FFFF_FFFF) begin
            $display("[TB] FAIL idle_no_write got=%h exp=%h", rdata, 64'h1122_3344_FFFF_FFFF); miscompares++;
        end
    endtask

    task automatic test_noop_write();
        drive(1'b1, 1'b1, 10'd5, 64'h0, 8'h00, 1'b1);
        cycle();
        vectors++;
        if (rdata !== 64'h1122_3344_FFFF_FFFF) begin
            $display("[TB] FAIL noop_data got=%h exp=%h", rdata, 64'h1122_3344_FFFF_FFFF); miscompares++;
        end
        vectors++;
        if (ruser !== 1'b0) begin
            $display("[TB] FAIL noop_user got=%b exp=0", ruser); miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        logic        opWe   [4];
        logic [9:0]  opAddr [4];
        logic [63:0] opData [4];
        logic        opUser [4];
        logic [63:0] expData [4];
        logic        expUser [4];
        opWe = '{1'b1, 1'b1, 1'b0, 1'b0};
        opAddr = '{10'd10, 10'd11, 10'd10, 10'd11};
        opData = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'h0, 64'h0};
        opUser = '{1'b1, 1'b0, 1'b0, 1'b0};
        expData = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
                    64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
        expUser = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, opWe[i], opAddr[i], opData[i], 8'hFF, opUser[i]);
            cycle();
            vectors++;
            if (rdata !== expData[i] || ruser !== expUser[i]) begin
                $display("[TB] FAIL b2b_op%0d got=%h/%b exp=%h/%b", i, rdata, ruser, expData[i], expUser[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] exp3;
        logic [63:0] exp5;
        drive(1'b1, 1'b1, 10'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
        cycle();
        rst = 1'b1;
        drive(1'b1, 1'b1, 10'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
        cycle();
        vectors++;
        if (rdata !== 64'h0 || ruser !== 1'b0) begin
            $display("[TB] FAIL midrst_out got=%h/%b exp=0/0", rdata, ruser); miscompares++;
        end
        rst = 1'b0;
        drive(1'b1, 1'b0, 10'd3, 64'h0, 8'h00, 1'b0);
        cycle();
`ifdef SRAM_CLEAR_ON_RESET_EN
        exp3 = 64'h0;
        exp5 = 64'h0;
`else
        exp3 = 64'h0123_4567_89AB_CDEF;
        exp5 = 64'h1122_3344_FFFF_FFFF;
`endif
        vectors++;
        if (rdata !== exp3) begin
            $display("[TB] FAIL midrst_addr3 got=%h exp=%h", rdata, exp3); miscompares++;
        end
        drive(1'b1, 1'b0, 10'd5, 64'h0, 8'h00, 1'b0);
        cycle();
        vectors++;
        if (rdata !== exp5) begin
            $display("[TB] FAIL midrst_addr5 got=%h exp=%h", rdata, exp5); miscompares++;
        end
        drive(1'b0, 1'b0, 10'd0, 64'h0, 8'h00, 1'b0);
    endtask

    task automatic test_out_of_range();
        logic [63:0] expWord;
        for (int i = 0; i < 6; i++) begin
            req6 = 1'b1; we6 = 1'b1; addr6 = 3'(i); be6 = 8'hFF; wuser6 = i[0];
            wdata6 = 64'h0101_0101_0101_0101 * 64'(i + 1);
            cycle();
        end
        req6 = 1'b1; we6 = 1'b1; addr6 = 3'd7; be6 = 8'hFF; wuser6 = 1'b1;
        wdata6 = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle();
        we6 = 1'b0; addr6 = 3'd7;
        cycle();
        vectors++;
        if (rdata6 !== 64'h0 || ruser6 !== 1'b0) begin
            $display("[TB] FAIL oor_read7 got=%h/%b exp=0/0", rdata6, ruser6); miscompares++;
        end
        for (int i = 0; i < 6; i++) begin
            addr6 = 3'(i);
            cycle();
            expWord = 64'h0101_0101_0101_0101 * 64'(i + 1);
            vectors++;
            if (rdata6 !== expWord || ruser6 !== i[0]) begin
                $display("[TB] FAIL oor_addr%0d got=%h/%b exp=%h/%b", i, rdata6, ruser6, expWord, i[0]);
                miscompares++;
            end
        end
        req6 = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 10'd0, 64'h0, 8'h00, 1'b0);
        req6 = 1'b0; we6 = 1'b0; addr6 = 3'd0; wuser6 = 1'b0; wdata6 = 64'h0; be6 = 8'h00;
        test_reset();
        test_full_write_read();
        test_partial_write();
        test_write_first();
        test_hold();
        test_noop_write();
        test_back_to_back();
        test_reset_mid_op();
        test_out_of_range();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram.md
SRAM -- requirements
Module: sram

Interface
- REQ-001: DATA_WIDTH, default 64; data word width in bits.
- REQ-002: USER_WIDTH, default 1; width of the user sideband stored with each word.
- REQ-003: BYTE_WIDTH, default 8; bits per byte-enable lane.
- REQ-004: NUM_WORDS, default 1024; depth in words.
- REQ-005: Derived widths:
  - AW = max(1, ceil(log2(NUM_WORDS))).
  - BW = ceil(DATA_WIDTH/BYTE_WIDTH).
- REQ-006: clk_i  input  1; single clock, all activity on rising edge.
- REQ-007: rst_ni  input  1; reset, synchronous and active-high. Name is kept for codebase compatibility; the _ni suffix does not imply active-low.
- REQ-008: req_i  input  1; access request, one access per cycle.
- REQ-009: we_i  input  1; 1 = write, 0 = read; only meaningful with req_i.
- REQ-010: addr_i  input  AW; word address.
- REQ-011: wuser_i  input  USER_WIDTH; user sideband write data.
- REQ-012: wdata_i  input  DATA_WIDTH; write data.
- REQ-013: be_i  input  BW; byte enables; lane k covers bits [k*BYTE_WIDTH +: BYTE_WIDTH], last lane truncated at DATA_WIDTH.
- REQ-014: ruser_o  output  USER_WIDTH; user sideband read data.
- REQ-015: rdata_o  output  DATA_WIDTH; read data.

Function
- REQ-016: Write, when req_i=1 and we_i=1 at a clock edge:
  - each lane k with be_i[k]=1 takes wdata_i's lane k;
  - lanes with be_i[k]=0 keep their prior contents;
  - the stored user field takes wuser_i when be_i has at least one bit set, otherwise it is unchanged.
- REQ-017: Read, when req_i=1 and we_i=0 at edge N: rdata_o/ruser_o show the word at addr_i after edge N and hold it until the next accepted request (1-cycle latency).
- REQ-018: Write-first. An accepted write also updates rdata_o/ruser_o after the edge, to the post-write contents of the addressed word.
- REQ-019: With req_i=0, the memory and rdata_o/ruser_o hold their values; we_i, be_i and the data inputs are don't-care.
- REQ-020: Out-of-range address (addr_i >= NUM_WORDS, only possible for non-power-of-2 depth):
  - writes are ignored;
  - reads return all-zero rdata_o/ruser_o.
- REQ-021: Back-to-back accesses in consecutive cycles are fully supported; there is no stall or handshake.
- REQ-022: be_i=0 with we_i=1 is a legal no-op write; rdata_o still returns the unmodified addressed word.

Reset
- REQ-023: While rst_ni=1 at a clock edge, rdata_o and ruser_o become 0 and any concurrent request is ignored.
- REQ-024: Memory contents are affected by reset only as defined in REQ-025/REQ-026.

Configuration
- REQ-025: With SRAM_CLEAR_ON_RESET_EN defined: every word and every user field is cleared to 0 on each reset edge. A read issued on the first cycle after reset deasserts returns 0 at every address.
- REQ-026: Without SRAM_CLEAR_ON_RESET_EN: memory contents are untouched by reset. Uninitialized words read X in simulation; no reset logic is placed on the array.

Verification
- REQ-027: Full write then read. Write addr 5, data 0x1122334455667788, be all ones, wuser 1; next cycle read addr 5 -> rdata_o=0x1122334455667788 and ruser_o=1 one cycle after the read.
- REQ-028: Partial write. Write addr 5, data 0xFFFFFFFFFFFFFFFF, be=0x0F, on top of REQ-027's word; read addr 5 -> 0x11223344FFFFFFFF.
- REQ-029: Write-first. Write addr 9, data 0xA5 (low lane, be=0x01) -> rdata_o low byte=0xA5 in the following cycle, with no separate read issued.
- REQ-030: Hold. Read addr 5, then drop req_i for 3 cycles while addr_i/we_i toggle -> rdata_o stays stable at addr 5's word.
- REQ-031: Reset mid-operation. Assert rst_ni during a write to addr 3 ->
  - rdata_o=0 after the edge;
  - addr 3 is unchanged;
  - with SRAM_CLEAR_ON_RESET_EN, all words read 0 afterwards.
- REQ-032: Non-power-of-2 depth, NUM_WORDS=6. Write addr 7, then read addr 7 -> rdata_o=0, and addresses 0-5 are unaffected.
